// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

  // Scan chain length: state (2) + counter + carry (1) + a_sh, b_sh, res.
  function automatic int scan_len(input int width, input int cnt_w);
    return 3 + cnt_w + 3 * width;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational one-bit full adder.
module fa_cell (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Sum,
  output logic Carry
);

  // Sum and majority carry of the three input bits.
  always_comb begin
    Sum   = A ^ B ^ C;
    Carry = (A & B) | (A & C) | (B & C);
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: operands accepted via valid/ready, added
// LSB-first through a single full-adder cell, result offered via valid/ready.
// Optional scan chain over all flops when SERIAL_ADD_SCAN_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
`ifdef SERIAL_ADD_SCAN_EN
  input  logic             Scan_en,
  input  logic             Scan_in,
  output logic             Scan_out,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             fa_sum, fa_carry;

  fa_cell u_fa (
    .A     (a_sh[0]),
    .B     (b_sh[0]),
    .C     (carry),
    .Sum   (fa_sum),
    .Carry (fa_carry)
  );

`ifdef SERIAL_ADD_SCAN_EN
  localparam int SCAN_L = scan_len(WIDTH, CNT_W);
  logic [SCAN_L-1:0] chain, chain_nxt;

  // Scan_in enters at the state MSB; res[0] is the chain tail.
  always_comb begin
    chain     = {state, cnt, carry, a_sh, b_sh, res};
    chain_nxt = {Scan_in, chain[SCAN_L-1:1]};
  end

  assign Scan_out = res[0];
`endif

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_sum   = '0;
    out_carry = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_sum   = res;
        out_carry = carry;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and serial datapath; scan shift overrides functional update.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
    end else
`ifdef SERIAL_ADD_SCAN_EN
    if (Scan_en) begin
      state <= state_t'(chain_nxt[SCAN_L-1 -: 2]);
      cnt   <= chain_nxt[SCAN_L-3 -: CNT_W];
      carry <= chain_nxt[3*WIDTH];
      a_sh  <= chain_nxt[3*WIDTH-1 -: WIDTH];
      b_sh  <= chain_nxt[2*WIDTH-1 -: WIDTH];
      res   <= chain_nxt[WIDTH-1:0];
    end else
`endif
    begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          res   <= {fa_sum, res[WIDTH-1:1]};
          carry <= fa_carry;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          // Hold at the last count so it never runs past WIDTH-1.
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed + random bench for serial_add_ctrl with a result scoreboard.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         Clock = 1'b0;
  logic         Reset_n;
  logic         in_valid, in_ready;
  logic [W-1:0] op_a, op_b;
  logic         cin;
  logic         out_valid, out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         busy;
`ifdef SERIAL_ADD_SCAN_EN
  logic         Scan_en, Scan_in, Scan_out;
`endif

  int total = 0;
  int bad   = 0;
  logic [W:0] sb[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
`ifdef SERIAL_ADD_SCAN_EN
    .Scan_en   (Scan_en),
    .Scan_in   (Scan_in),
    .Scan_out  (Scan_out),
`endif
    .busy      (busy)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One transaction with hold cycles of backpressure before out_ready.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic [W:0] exp, input int hold);
    int n;
    logic [W:0] snap, e;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    tick();
    sb.push_back(exp);
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b; cin = ~c;
    n = 0;
    while (!out_valid && n < 3 * W) begin tick(); n++; end
    chk({tag, "_lat"}, 64'(n), 64'(W));
    snap = {out_carry, out_sum};
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_val"}, 64'({out_carry, out_sum}), 64'(snap));
      chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    if (sb.size() > 0) e = sb.pop_front(); else e = 'x;
    chk({tag, "_res"}, 64'({out_carry, out_sum}), 64'(e));
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_vld"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, last_acc, n_acc, n_done;
    logic acc;
    logic [W:0] e;
    logic [W-1:0] ra, rb;
    logic rc;

    Reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0;
`ifdef SERIAL_ADD_SCAN_EN
    Scan_en = 1'b0; Scan_in = 1'b0;
`endif
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_carry", 64'(out_carry), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    Reset_n = 1'b1;
    tick();

    do_op("basic", 8'h5A, 8'h3C, 1'b0, 9'h096, 0);
    do_op("ripple1", 8'hFF, 8'h01, 1'b0, 9'h100, 0);
    do_op("ripple2", 8'hFF, 8'hFF, 1'b1, 9'h1FF, 0);
    do_op("bp", 8'hA7, 8'h6E, 1'b1, 9'h116, 5);

    // Reset during RUN at cnt==3.
    op_a = 8'h77; op_b = 8'h11; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("mid_busy_pre", 64'(busy), 64'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_in_ready", 64'(in_ready), 64'd1);
    #2;
    Reset_n = 1'b1;
    tick();
    do_op("post_rst", 8'h10, 8'h20, 1'b0, 9'h030, 0);

    // Back-to-back random operands, in_valid held, out_ready high.
    cyc = 0; last_acc = -1; n_acc = 0; n_done = 0;
    ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
    op_a = ra; op_b = rb; cin = rc;
    in_valid = 1'b1; out_ready = 1'b1;
    while (n_done < 20 && cyc < 2000) begin
      if (out_valid) begin
        if (sb.size() > 0) e = sb.pop_front(); else e = 'x;
        chk("b2b_res", 64'({out_carry, out_sum}), 64'(e));
        n_done++;
      end
      acc = in_ready && in_valid;
      if (acc) begin
        sb.push_back((W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc));
        if (last_acc >= 0) chk("b2b_gap", 64'(cyc - last_acc), 64'(W + 2));
        last_acc = cyc;
        n_acc++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (n_acc < 20) begin
          ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
          op_a = ra; op_b = rb; cin = rc;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", 64'(n_done), 64'd20);
    out_ready = 1'b0;

`ifdef SERIAL_ADD_SCAN_EN
    begin
      localparam int L = 3 + $clog2(W) + 3 * W;
      logic [63:0] pat;
      pat = {$urandom, $urandom};
      Scan_en = 1'b1;
      in_valid = 1'b1;
      for (int k = 1; k <= 2 * L; k++) begin
        Scan_in = (k <= L) ? pat[k-1] : 1'b0;
        tick();
        if (k >= L && k < 2 * L) chk("scan_bit", 64'(Scan_out), 64'(pat[k-L]));
      end
      Scan_en = 1'b0;
      in_valid = 1'b0;
      Reset_n = 1'b0;
      #2;
      Reset_n = 1'b1;
      tick();
      do_op("post_scan", 8'h01, 8'h02, 1'b1, 9'h004, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
